spi_slave: RTL and testbench

SPI bus responder (target). It is the far-end counterpart of the team's spi_master, for on-board test loopback and for FPGA-to-FPGA links.
- Bus format: mode 0 (sample on scl rise, change on scl fall), MSB first, active-low chip select.
- scl/scs/sdi are asynchronous to clk_i and are oversampled.
- Local side is a simple parallel interface suitable for wrapping in an rbus register.

---
 rtl/spi_slave.sv | 146 ++++++++++++++
 tb/tb_spi_slave.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/spi_slave.sv
// SPI mode-0 target: oversampled scl/scs/sdi, MSB-first shift in both directions,
// with a one-word tx holding register and a parallel rx word output.
module spi_slave #(
  parameter int DATA_W = 32,
  parameter int SYNC_W = 2
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              scl_i,
  input  logic              scs_i,
  input  logic              sdi_i,
  output logic              sdo_o,
  output logic              sdo_oe_o,
  input  logic [DATA_W-1:0] tx_data_i,
  input  logic              tx_wr_i,
  output logic              tx_empty_o,
  output logic              tx_unf_o,
  output logic [DATA_W-1:0] rx_data_o,
  output logic              rx_valid_o,
  output logic              busy_o
);
  localparam int CW = (DATA_W > 2) ? $clog2(DATA_W) : 1;

  typedef enum logic {IDLE, SHIFT} state_t;
  state_t state, state_nx;

  logic [SYNC_W-1:0] scl_s, scs_s, sdi_s;
  logic [SYNC_W:0]   prime;
  logic              scl_l, scs_l, sdi_l;
  logic              scl_rise, scl_fall, scs_rise, scs_fall;
  logic              armed, word_end;
  logic [CW-1:0]     bit_cnt;
  logic [DATA_W-1:0] tx_sr, rx_sr, hold;
  logic              start, load;

  // Synchronizers feed a level register; events are registered against it.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      scl_s    <= '0;
      scs_s    <= '1;
      sdi_s    <= '0;
      scl_l    <= 1'b0;
      scs_l    <= 1'b1;
      sdi_l    <= 1'b0;
      scl_rise <= 1'b0;
      scl_fall <= 1'b0;
      scs_rise <= 1'b0;
      scs_fall <= 1'b0;
      prime    <= '0;
      armed    <= 1'b0;
    end else begin
      scl_s    <= {scl_s[SYNC_W-2:0], scl_i};
      scs_s    <= {scs_s[SYNC_W-2:0], scs_i};
      sdi_s    <= {sdi_s[SYNC_W-2:0], sdi_i};
      scl_l    <= scl_s[SYNC_W-1];
      scs_l    <= scs_s[SYNC_W-1];
      sdi_l    <= sdi_s[SYNC_W-1];
      scl_rise <= scl_s[SYNC_W-1] & ~scl_l;
      scl_fall <= ~scl_s[SYNC_W-1] & scl_l;
      scs_rise <= scs_s[SYNC_W-1] & ~scs_l;
      scs_fall <= ~scs_s[SYNC_W-1] & scs_l;
      // The reset value of the scs chain is not a real pin sample; only arm once
      // a genuine high has travelled the whole chain.
      prime    <= {prime[SYNC_W-1:0], 1'b1};
      if (prime[SYNC_W] && scs_s[SYNC_W-1]) armed <= 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    start    = 1'b0;
    if (scs_rise) state_nx = IDLE;
    else if (state == IDLE && scs_fall && armed) begin
      state_nx = SHIFT;
      start    = 1'b1;
    end
  end

  assign load   = start || (state == SHIFT && !scs_rise && !scl_rise && scl_fall && word_end);
  assign busy_o = (state == SHIFT);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      hold       <= '0;
      tx_empty_o <= 1'b1;
    end else if (tx_wr_i) begin
      hold       <= tx_data_i;
      tx_empty_o <= 1'b0;
    end else if (load) begin
      tx_empty_o <= 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sdo_o      <= 1'b0;
      sdo_oe_o   <= 1'b0;
      tx_unf_o   <= 1'b0;
      rx_data_o  <= '0;
      rx_valid_o <= 1'b0;
      tx_sr      <= '0;
      rx_sr      <= '0;
      bit_cnt    <= '0;
      word_end   <= 1'b0;
    end else begin
      rx_valid_o <= 1'b0;
      tx_unf_o   <= 1'b0;
      if (scs_rise) begin
        sdo_oe_o <= 1'b0;
        bit_cnt  <= '0;
        word_end <= 1'b0;
      end else if (start) begin
        sdo_oe_o <= 1'b1;
        bit_cnt  <= '0;
        word_end <= 1'b0;
      end else if (state == SHIFT && scl_rise) begin
        rx_sr <= {rx_sr[DATA_W-2:0], sdi_l};
        if (bit_cnt == CW'(DATA_W-1)) begin
          rx_data_o  <= {rx_sr[DATA_W-2:0], sdi_l};
          rx_valid_o <= 1'b1;
          bit_cnt    <= '0;
          word_end   <= 1'b1;
        end else begin
          bit_cnt <= bit_cnt + 1'b1;
        end
      end else if (state == SHIFT && scl_fall) begin
        if (word_end) word_end <= 1'b0;
        else begin
          tx_sr <= tx_sr << 1;
          sdo_o <= tx_sr[DATA_W-2];
        end
      end
      // Empty holding register sends an all-zero word and flags the underrun.
      if (load) begin
        tx_sr    <= tx_empty_o ? '0 : hold;
        sdo_o    <= tx_empty_o ? 1'b0 : hold[DATA_W-1];
        tx_unf_o <= tx_empty_o;
      end
    end
  end
endmodule

// File: tb/tb_spi_slave.sv
// Bench for spi_slave: a bit-banged mode-0 master with a word-level model of the
// tx holding register, underrun count and expected rx words.
module tb_spi_slave;
  localparam int DW = 8;
  localparam int SW = 2;
  localparam int H  = 8;

  logic          clk = 1'b0, rst = 1'b1;
  logic          scl = 1'b0, scs = 1'b1, sdi = 1'b0, tx_wr = 1'b0;
  logic [DW-1:0] tx_data = '0;
  logic          sdo, sdo_oe, tx_empty, tx_unf, rx_valid, busy;
  logic [DW-1:0] rx_data;

  spi_slave #(.DATA_W(DW), .SYNC_W(SW)) dut (
    .clk_i(clk), .rst_i(rst), .scl_i(scl), .scs_i(scs), .sdi_i(sdi),
    .sdo_o(sdo), .sdo_oe_o(sdo_oe), .tx_data_i(tx_data), .tx_wr_i(tx_wr),
    .tx_empty_o(tx_empty), .tx_unf_o(tx_unf), .rx_data_o(rx_data),
    .rx_valid_o(rx_valid), .busy_o(busy)
  );

  always #5 clk = ~clk;

  int         cyc = 0, n_cmp = 0, n_err = 0, unf_cnt = 0;
  logic [7:0] rx_q[$];
  int         rxc_q[$];

  always @(posedge clk) begin
    cyc++;
    #1;
    if (rx_valid) begin
      rx_q.push_back(rx_data);
      rxc_q.push_back(cyc);
    end
    if (tx_unf) unf_cnt++;
  end

  // reference model state
  logic [7:0] hold = '0;
  bit         hold_empty = 1'b1;
  int         exp_unf = 0;
  logic [7:0] last_rx = '0;
  logic [7:0] mw[4];

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic half();
    repeat (H) @(negedge clk);
  endtask

  task automatic model_load(output logic [7:0] w);
    if (hold_empty) begin
      w = '0;
      exp_unf++;
    end else w = hold;
    hold_empty = 1'b1;
  endtask

  task automatic tx_write(input logic [7:0] d);
    @(negedge clk);
    tx_data = d;
    tx_wr   = 1'b1;
    @(negedge clk);
    tx_wr      = 1'b0;
    hold       = d;
    hold_empty = 1'b0;
  endtask

  // n words from mw[]; abort after cut bits; reset after rst_at bits
  task automatic run_frame(input int n, input int cut, input int rst_at,
                           input bit mid_en, input logic [7:0] mid_val);
    logic [7:0] exp_tx[4];
    logic [7:0] got[4];
    logic [7:0] t;
    int         rise_c[4];
    int         bits, full;
    bit         dead, stop;
    bits = 0; full = 0; dead = 0; stop = 0;
    rx_q.delete();
    rxc_q.delete();
    @(negedge clk);
    scs = 1'b0;
    model_load(exp_tx[0]);
    sdi = mw[0][7];
    half();
    chk("busy_on", busy, 1);
    chk("oe_on", sdo_oe, 1);
    chk("empty_start", tx_empty, hold_empty);
    for (int w = 0; w < n && !stop; w++) begin
      for (int b = 7; b >= 0 && !stop; b--) begin
        scl = 1'b1;
        got[w][b] = sdo;
        rise_c[w] = cyc;
        half();
        scl = 1'b0;
        bits++;
        if (b == 0 && !dead) begin
          full = w + 1;
          if (w + 1 < n) model_load(exp_tx[w+1]);
          else model_load(t);
        end
        if (b == 0 && w + 1 < n) sdi = mw[w+1][7];
        else if (b > 0) sdi = mw[w][b-1];
        if (mid_en && w == 0 && b == 4) tx_write(mid_val);
        if (bits == rst_at) begin
          rst = 1'b1;
          @(negedge clk);
          rst = 1'b0;
          hold_empty = 1'b1;
          last_rx = '0;
          dead = 1'b1;
        end
        if (bits == cut) stop = 1'b1;
        half();
      end
    end
    scs = 1'b1;
    half();
    half();
    chk("rx_count", rx_q.size(), full);
    for (int w = 0; w < full; w++) begin
      chk("sdo_word", got[w], exp_tx[w]);
      if (w < rx_q.size()) begin
        chk("rx_word", rx_q[w], mw[w]);
        chk("rx_latency", rxc_q[w] - rise_c[w], SW + 2);
      end
      last_rx = mw[w];
    end
    chk("rx_data_hold", rx_data, last_rx);
    chk("unf_count", unf_cnt, exp_unf);
    chk("empty_end", tx_empty, hold_empty);
    chk("oe_off", sdo_oe, 0);
    chk("busy_off", busy, 0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_sdo", sdo, 0);
    chk("rst_oe", sdo_oe, 0);
    chk("rst_empty", tx_empty, 1);
    chk("rst_busy", busy, 0);
    rst = 1'b0;
    repeat (SW + 3) @(negedge clk);
    chk("rel_rx_data", rx_data, 0);
    chk("rel_rx_valid", rx_valid, 0);
    chk("rel_unf", unf_cnt, 0);
    chk("rel_rxq", rx_q.size(), 0);

    // single word
    tx_write(8'hA5);
    mw[0] = 8'h3C;
    run_frame(1, 99, 99, 0, 0);

    // two words in one frame, second tx word written mid-word
    tx_write(8'h12);
    mw[0] = 8'hF0; mw[1] = 8'h0F;
    run_frame(2, 99, 99, 1, 8'h34);

    // underrun
    mw[0] = 8'($urandom);
    run_frame(1, 99, 99, 0, 0);

    // abort after 5 bits, then a clean frame
    tx_write(8'h77);
    mw[0] = 8'($urandom);
    run_frame(1, 5, 99, 0, 0);
    mw[0] = 8'h81;
    run_frame(1, 99, 99, 0, 0);

    // reset mid-frame, then a clean frame
    tx_write(8'h5A);
    mw[0] = 8'($urandom);
    run_frame(1, 99, 3, 0, 0);
    half();
    mw[0] = 8'hC3;
    run_frame(1, 99, 99, 0, 0);

    // random frames
    for (int k = 0; k < 6; k++) begin
      int nw;
      nw = $urandom_range(1, 3);
      for (int w = 0; w < 4; w++) mw[w] = 8'($urandom);
      if ($urandom_range(0, 1) == 1) tx_write(8'($urandom));
      run_frame(nw, 99, 99, 1'($urandom_range(0, 1)), 8'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
